// File: rtl/aes_mode_engine.sv
// ---------------------------------------------------------------------------
// aes_mode_engine -- AES-128 block engine with ECB and CBC chaining.
//
// Contents (single self-contained design file):
//   aes_mode_pkg   : GF(2^8) arithmetic and AES round primitives.
//   key_expansion  : combinational AES-128 key schedule (11 round keys).
//   aes_cipher     : iterative encryptor, one round per clock.
//   aes_decipher   : iterative decryptor, one round per clock.
//   aes_mode_engine: top level; handshakes, key/IV/chain registers, FSM.
//
// Top-level ports:
//   clk       in   clock, all state changes on its rising edge
//   rst       in   asynchronous active-low reset
//   key_load  in   pulse, captures key_in (IDLE only)
//   key_in    in   cipher key
//   iv_load   in   pulse, captures iv_in into the chain register (IDLE only)
//   iv_in     in   CBC initialisation vector
//   mode_cbc  in   1=CBC, 0=ECB, sampled at block accept
//   dir_dec   in   1=decrypt, 0=encrypt, sampled at block accept
//   in_valid  in   / in_ready out / in_data in   : input block handshake
//   out_valid out  / out_ready in / out_data out : result handshake
//   busy      out  high whenever the FSM is not IDLE
//   err       out  sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------

package aes_mode_pkg;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0,
    // which is exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box computed rather than tabulated: inverse followed by affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(v);
    endfunction

    // Byte i of the state lives at bits [127-8i -: 8]; state is column-major,
    // so row r / column c is byte r + 4c.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (inv)
                    o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
                else
                    o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (inv) begin
                o[127-32*c -: 32] = {
                    gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                    gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                    gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                    gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
            end else begin
                o[127-32*c -: 32] = {
                    gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
                    a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
                    a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
                    gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
            end
        end
        return o;
    endfunction

    // Round key r is returned at bits [r*128 +: 128].
    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] rks;
        rks  = '0;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return rks;
    endfunction

endpackage

// Combinational key schedule; recomputed whenever the key register changes.
module key_expansion (
    input  logic [127:0]  key_i,
    output logic [1407:0] round_keys_o
);
    import aes_mode_pkg::*;
    assign round_keys_o = expand_key(key_i);
endmodule

// Iterative encryptor. start_i loads the block with the initial key whitening,
// then rounds 1..10 run one per clock; done_o pulses for one cycle with the
// ciphertext on data_o.
module aes_cipher (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [127:0]  data_i,
    input  logic [1407:0] round_keys_i,
    output logic [127:0]  data_o,
    output logic          done_o
);
    import aes_mode_pkg::*;

    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         active_q, active_d;
    logic         done_q, done_d;
    logic [127:0] tmp;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        active_d = active_q;
        done_d   = 1'b0;
        tmp      = '0;
        if (start_i) begin
            state_d  = data_i ^ round_keys_i[127:0];
            round_d  = 4'd1;
            active_d = 1'b1;
        end else if (active_q) begin
            tmp = shift_rows(sub_bytes(state_q, 1'b0), 1'b0);
            // The last round skips MixColumns.
            if (round_q != 4'd10) tmp = mix_columns(tmp, 1'b0);
            state_d = tmp ^ round_keys_i[{round_q, 7'd0} +: 128];
            if (round_q == 4'd10) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= '0;
            round_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign data_o = state_q;
    assign done_o = done_q;
endmodule

// Iterative decryptor (straight inverse cipher). Rounds count down 9..0 so the
// latency matches aes_cipher exactly.
module aes_decipher (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [127:0]  data_i,
    input  logic [1407:0] round_keys_i,
    output logic [127:0]  data_o,
    output logic          done_o
);
    import aes_mode_pkg::*;

    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         active_q, active_d;
    logic         done_q, done_d;
    logic [127:0] tmp;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        active_d = active_q;
        done_d   = 1'b0;
        tmp      = '0;
        if (start_i) begin
            state_d  = data_i ^ round_keys_i[1407:1280];
            round_d  = 4'd9;
            active_d = 1'b1;
        end else if (active_q) begin
            tmp = sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ round_keys_i[{round_q, 7'd0} +: 128];
            // Round key 0 closes the last round, which has no InvMixColumns.
            if (round_q != 4'd0) tmp = mix_columns(tmp, 1'b1);
            state_d = tmp;
            if (round_q == 4'd0) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                round_d = round_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= '0;
            round_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign data_o = state_q;
    assign done_o = done_q;
endmodule

module aes_mode_engine #(
    parameter int DATA_WIDTH = 128,
    parameter bit CBC_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_load,
    input  logic [DATA_WIDTH-1:0] key_in,
    input  logic                  iv_load,
    input  logic [DATA_WIDTH-1:0] iv_in,
    input  logic                  mode_cbc,
    input  logic                  dir_dec,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] key_q, chain_q, pend_q, core_in_q, out_data_q;
    logic                  key_valid_q, dec_q, cbc_q, start_q, err_q;

    logic [1407:0]         round_keys;
    logic [DATA_WIDTH-1:0] enc_out, dec_out;
    logic                  enc_done, dec_done;
    logic                  accept, cbc_eff, sel_done, finish;

    assign accept   = in_valid & in_ready;
    assign cbc_eff  = mode_cbc & CBC_EN;
    // Only the core that was started may end the RUN state.
    assign sel_done = dec_q ? dec_done : enc_done;
    assign finish   = (state_q == RUN) & sel_done;

    key_expansion u_key_expansion (
        .key_i        (key_q),
        .round_keys_o (round_keys)
    );

    aes_cipher u_cipher (
        .clk_i        (clk),
        .rst_ni       (rst),
        .start_i      (start_q & ~dec_q),
        .data_i       (core_in_q),
        .round_keys_i (round_keys),
        .data_o       (enc_out),
        .done_o       (enc_done)
    );

    aes_decipher u_decipher (
        .clk_i        (clk),
        .rst_ni       (rst),
        .start_i      (start_q & dec_q),
        .data_i       (core_in_q),
        .round_keys_i (round_keys),
        .data_o       (dec_out),
        .done_o       (dec_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (sel_done)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // in_ready only in IDLE, so the HOLD->IDLE cycle can never also accept.
    always_comb begin
        in_ready  = (state_q == IDLE) & key_valid_q;
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_data  = out_data_q;
        err       = err_q;
    end

    // Datapath: key/IV capture, block accept (start pulse is registered so the
    // core sees a clean one-cycle strobe) and result/chain update on done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q       <= '0;
            key_valid_q <= 1'b0;
            chain_q     <= '0;
            pend_q      <= '0;
            core_in_q   <= '0;
            out_data_q  <= '0;
            dec_q       <= 1'b0;
            cbc_q       <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= accept;

            if (state_q == IDLE) begin
                if (key_load) begin
                    key_q       <= key_in;
                    key_valid_q <= 1'b1;
                end
                if (iv_load) chain_q <= iv_in;
            end else if (key_load || iv_load) begin
                err_q <= 1'b1;
            end

            if (in_valid && !key_valid_q) err_q <= 1'b1;

            if (accept) begin
                dec_q     <= dir_dec;
                cbc_q     <= cbc_eff;
                core_in_q <= (cbc_eff && !dir_dec) ? (in_data ^ chain_q) : in_data;
                if (cbc_eff && dir_dec) pend_q <= in_data;
            end

            if (finish) begin
                if (dec_q) out_data_q <= cbc_q ? (dec_out ^ chain_q) : dec_out;
                else       out_data_q <= enc_out;
                if (cbc_q) chain_q <= dec_q ? pend_q : enc_out;
            end
        end
    end
endmodule

// File: tb/tb_aes_mode_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_mode_engine -- directed-vector bench for aes_mode_engine.
// Stimulus pushes the expected result of each block into a queue; a monitor
// pops and compares on every completed output handshake.
// ---------------------------------------------------------------------------
module tb_aes_mode_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         iv_load = 1'b0;
    logic [127:0] iv_in = '0;
    logic         mode_cbc = 1'b0;
    logic         dir_dec = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;
    logic         err;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2A  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2B  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2A  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2B  = 128'h5086cb9b507219ee95db113a917678b2;

    logic [127:0] expQ[$];
    int vectorCount = 0;
    int missCount   = 0;
    int xferCount   = 0;

    aes_mode_engine #(.DATA_WIDTH(128), .CBC_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .iv_load   (iv_load),
        .iv_in     (iv_in),
        .mode_cbc  (mode_cbc),
        .dir_dec   (dir_dec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            xferCount++;
            if (expQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL unexpected_output: got %h, want no output", out_data);
            end else begin
                checkOutput("out_data", out_data, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [127:0] data, input logic dec, input logic cbc,
                                 input logic [127:0] expected, input bit track);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, want 1");
            return;
        end
        in_data  = data;
        dir_dec  = dec;
        mode_cbc = cbc;
        in_valid = 1'b1;
        if (track) expQ.push_back(expected);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitDrained();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (expQ.size() != 0) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL drain_timeout: got %0d pending, want 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic loadKey(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic loadIv(input logic [127:0] v);
        iv_in   = v;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int xferBefore;
        int n;
        int staleCount;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",  128'(in_ready),  128'd0);
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_out_data",  out_data,        128'd0);
        checkOutput("rst_busy",      128'(busy),      128'd0);
        checkOutput("rst_err",       128'(err),       128'd0);
        tick();
        rst = 1'b1;

        // Block offered before any key: refused, err set.
        in_data  = PT1;
        in_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("nokey_in_ready", 128'(in_ready), 128'd0);
        checkOutput("nokey_busy",     128'(busy),     128'd0);
        checkOutput("nokey_err",      128'(err),      128'd1);
        tick();
        in_valid = 1'b0;

        // err is cleared only by reset.
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_clears_err", 128'(err), 128'd0);
        tick();
        rst = 1'b1;

        // ECB encrypt and decrypt.
        loadKey(KEY1);
        @(negedge clk);
        checkOutput("key_ready", 128'(in_ready), 128'd1);
        tick();
        applyStimulus(PT1, 1'b0, 1'b0, CT1, 1'b1);
        waitDrained();
        applyStimulus(CT1, 1'b1, 1'b0, PT1, 1'b1);
        waitDrained();

        // CBC encrypt two blocks, then reload IV and decrypt them.
        loadKey(KEY2);
        loadIv(IV2);
        applyStimulus(P2A, 1'b0, 1'b1, C2A, 1'b1);
        applyStimulus(P2B, 1'b0, 1'b1, C2B, 1'b1);
        waitDrained();
        loadIv(IV2);
        applyStimulus(C2A, 1'b1, 1'b1, P2A, 1'b1);
        applyStimulus(C2B, 1'b1, 1'b1, P2B, 1'b1);
        waitDrained();

        // Backpressure: result must hold steady for 10 cycles, then one transfer.
        loadKey(KEY1);
        out_ready = 1'b0;
        applyStimulus(PT1, 1'b0, 1'b0, CT1, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("bp_out_valid_seen", 128'(out_valid), 128'd1);
        xferBefore = xferCount;
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
            checkOutput("bp_out_data",  out_data,        CT1);
            checkOutput("bp_in_ready",  128'(in_ready),  128'd0);
        end
        tick();
        out_ready = 1'b1;
        waitDrained();
        repeat (3) tick();
        checkOutput("bp_one_transfer", 128'(xferCount - xferBefore), 128'd1);

        // key_load during RUN: ignored, err set, block still uses the old key.
        applyStimulus(PT1, 1'b0, 1'b0, CT1, 1'b1);
        repeat (2) tick();
        loadKey(KEY2);
        @(negedge clk);
        checkOutput("busy_keyload_err", 128'(err), 128'd1);
        waitDrained();
        applyStimulus(PT1, 1'b0, 1'b0, CT1, 1'b1);
        waitDrained();

        // Reset mid-RUN: everything clears and no stale result appears.
        applyStimulus(PT1, 1'b0, 1'b0, CT1, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checkOutput("midrun_in_ready",  128'(in_ready),  128'd0);
        checkOutput("midrun_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midrun_out_data",  out_data,        128'd0);
        checkOutput("midrun_busy",      128'(busy),      128'd0);
        checkOutput("midrun_err",       128'(err),       128'd0);
        tick();
        rst = 1'b1;
        staleCount = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) staleCount++;
        end
        checkOutput("no_stale_out_valid", 128'(staleCount), 128'd0);
        checkOutput("post_reset_no_key",  128'(in_ready),   128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
